ds_scoreboard: RTL
==================

// Module: ds_scoreboard
// PURPOSE
//  Register-dependency scoreboard and interlock controller for the decode stage.
//  Tracks in-flight GPR writes between issue (ds->es handshake) and retire (ws->rf write).
//  Drives ds_stall, which decode ANDs into ds_ready_go, so RAW/WAW hazards hold the instruction in ID.
//  Sits beside id_stage; fed by decode fields and ws_to_rf_bus.
// PARAMETERS
//  NREG     32  number of architectural GPRs (r0 hardwired zero, never tracked)
//  AW       5   register address width, = clog2(NREG)
//  CNT_W    2   per-register in-flight counter width
//  CNT_MAX  3   max in-flight writes per register (EX+MEM+WB), <= 2**CNT_W-1
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-high reset
//  ds_valid     in   1    ID holds a valid instruction
//  src1_addr    in   AW   rj read address (rf_raddr1)
//  src1_used    in   1    instruction actually reads src1
//  src2_addr    in   AW   rk/rd read address (rf_raddr2)
//  src2_used    in   1    instruction actually reads src2
//  dst_addr     in   AW   destination (dest, incl. r1 for bl)
//  dst_we       in   1    instruction writes GPR (gr_we)
//  issue        in   1    ds_to_es_valid && es_allowin this cycle
//  rt_we        in   1    writeback strobe (rf_we)
//  rt_addr      in   AW   writeback address (rf_waddr)
//  flush        in   1    discard all in-flight tracking (pipeline kill)
//  ds_stall     out  1    hold ID; combinational from registered state
//  busy_vec     out  NREG bit i = cnt[i] != 0; bit 0 always 0
//  err_sticky   out  1    protocol error latched (underflow / illegal issue)
// BEHAVIOUR
//  - State: cnt[1..NREG-1], CNT_W bits each; err_sticky. Reset: all cnt=0, err_sticky=0,
//    hence busy_vec=0, ds_stall=0. Reset asserted mid-operation clears immediately (async).
//  - Stall (combinational, no retire bypass):
//    ds_stall = ds_valid & ( src1_used & busy(src1_addr) | src2_used & busy(src2_addr)
//               | dst_we & cnt[dst_addr]==CNT_MAX ); busy(0)=0.
//    Regfile writes at posedge, so a source retiring this cycle still stalls; released next cycle
//    (retire->dependent issue latency = 1 cycle after writeback cycle).
//  - inc = issue & dst_we & dst_addr!=0; dec = rt_we & rt_addr!=0.
//  - Per register i, next cycle: inc only -> +1; dec only -> -1; both same reg -> unchanged;
//    both different regs -> each updated independently.
//  - Counter never wraps: inc at CNT_MAX (only possible if issue ignored ds_stall) -> cnt holds,
//    err_sticky<=1. dec at 0 -> cnt holds 0, err_sticky<=1.
//  - issue while ds_stall=1 -> tracking still applied (saturating), err_sticky<=1.
//  - flush: all cnt<=0 next edge; flush beats inc/dec in same cycle; err_sticky unaffected.
//  - err_sticky clears only on reset.
//  - issue/rt signals with r0 address are ignored entirely (no error).
// STRUCTURE
//  - Shared header mycpu.h: NREG, AW, SB_CNT_W, SB_CNT_MAX defines.
//  - Sub-module sb_counter: one saturating up/down counter (inc, dec, clr, cnt, busy, at_max,
//    err pulse); generate NREG-1 instances, r0 slot tied off.
//  - Top: address decoders for dst/rt, read muxes for src1/src2/dst, stall OR, error OR-reduce.
// TESTING
//  - Reset: assert reset async mid-cycle with cnt[5]=2 -> busy_vec=0, ds_stall=0, err_sticky=0 at once.
//  - RAW: issue add r5 (dst_we=1,dst=5); next cycle src1=5,ds_valid=1 -> ds_stall=1;
//    rt_we=1,rt_addr=5 -> stall still 1 that cycle, 0 following cycle.
//  - Simultaneous: cnt[7]=1, issue dst=7 and retire 7 same cycle -> cnt[7]=1, busy_vec[7]=1 stays.
//  - Saturation: three issues dst=3 without retire -> cnt=3; dst=3 pending -> ds_stall=1; forced
//    issue -> cnt stays 3, err_sticky=1.
//  - r0/underflow: issue dst=0 -> busy_vec=0; rt_we addr=9 with cnt[9]=0 -> err_sticky=1, cnt 0.
//  - Flush: cnt[2]=2,cnt[4]=1, flush with concurrent issue dst=4 -> all cnt=0 next cycle, stall=0.

Source files
------------

// File: rtl/ds_scoreboard_pkg.sv
// ds_scoreboard_pkg
//   Shared sizing constants and types for the decode-stage register scoreboard.
//   NREG/AW describe the GPR file. SB_CNT_W/SB_CNT_MAX bound how many writes
//   to one register can be in flight (EX + MEM + WB).
//   sb_decode_op turns the raw inc/dec/clr strobes of one counter into a
//   single operation. Clear has priority. An inc and a dec together cancel.
package ds_scoreboard_pkg;

  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int SB_CNT_W = 2;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX  = 2'd3;
  localparam sb_cnt_t SB_CNT_ZERO = 2'd0;
  localparam sb_cnt_t SB_CNT_ONE  = 2'd1;

  typedef enum logic [1:0] {
    SB_OP_HOLD = 2'd0,
    SB_OP_INC  = 2'd1,
    SB_OP_DEC  = 2'd2,
    SB_OP_CLR  = 2'd3
  } sb_op_e;

  function automatic sb_op_e sb_decode_op(input logic inc, input logic dec, input logic clr);
    sb_op_e op;
    if (clr) begin
      op = SB_OP_CLR;
    end else if (inc & ~dec) begin
      op = SB_OP_INC;
    end else if (dec & ~inc) begin
      op = SB_OP_DEC;
    end else begin
      op = SB_OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/ds_scoreboard_sb_counter.sv
// ds_scoreboard_sb_counter
//   Counts the in-flight writes to one GPR. The counter saturates in both
//   directions. It never wraps.
//   Ports:
//     clk, reset : clock and asynchronous active-high reset
//     inc        : a write to this register was issued
//     dec        : a write to this register retired
//     clr        : pipeline flush, clears the count
//                  clr wins over inc/dec and never raises err
//     cnt        : current in-flight count
//     busy       : cnt != 0
//     err        : single-cycle pulse on overflow (inc at max) or
//                  underflow (dec at zero)
module ds_scoreboard_sb_counter
  import ds_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    inc,
  input  logic    dec,
  input  logic    clr,
  output sb_cnt_t cnt,
  output logic    busy,
  output logic    err
);

  sb_cnt_t cnt_r;
  sb_cnt_t cnt_nxt_s;
  logic    err_s;
  sb_op_e  op_s;

  // next-count and protocol-error evaluation
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_s     = 1'b0;
    op_s      = sb_decode_op(inc, dec, clr);
    case (op_s)
      SB_OP_CLR: begin
        cnt_nxt_s = SB_CNT_ZERO;
      end
      SB_OP_INC: begin
        if (cnt_r == SB_CNT_MAX) begin
          err_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + SB_CNT_ONE;
        end
      end
      SB_OP_DEC: begin
        if (cnt_r == SB_CNT_ZERO) begin
          err_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - SB_CNT_ONE;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // in-flight count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= SB_CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt  = cnt_r;
  assign busy = (cnt_r != SB_CNT_ZERO);
  assign err  = err_s;

endmodule

// File: rtl/ds_scoreboard.sv
// ds_scoreboard
//   Register-dependency scoreboard and interlock for the decode stage.
//   It tracks GPR writes between issue (ds->es handshake) and retire (the
//   regfile write). It raises ds_stall on a RAW hazard. It also stalls when
//   the destination already has the maximum number of writes in flight.
//   Ports:
//     clk, reset            : clock and asynchronous active-high reset
//     ds_valid              : ID holds a valid instruction
//     src1_addr / src1_used : first source and its use flag
//     src2_addr / src2_used : second source and its use flag
//     dst_addr / dst_we     : destination and its GPR-write flag
//     issue                 : instruction leaves ID this cycle
//     rt_we / rt_addr       : writeback strobe and address
//     flush                 : drop all in-flight tracking
//     ds_stall              : hold ID (combinational from registered counts)
//     busy_vec              : per-register busy flags, bit 0 always 0
//     err_sticky            : latched protocol error (over/underflow,
//                             issue while stalled)
//   r0 is never tracked. Issue and retire strobes that address r0 are ignored.
module ds_scoreboard
  import ds_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ds_valid,
  input  logic [AW-1:0]   src1_addr,
  input  logic            src1_used,
  input  logic [AW-1:0]   src2_addr,
  input  logic            src2_used,
  input  logic [AW-1:0]   dst_addr,
  input  logic            dst_we,
  input  logic            issue,
  input  logic            rt_we,
  input  logic [AW-1:0]   rt_addr,
  input  logic            flush,
  output logic            ds_stall,
  output logic [NREG-1:0] busy_vec,
  output logic            err_sticky
);

  localparam logic [AW-1:0] ADDR_R0 = 5'd0;

  logic            inc_s;
  logic            dec_s;
  logic [NREG-1:0] inc_vec_s;
  logic [NREG-1:0] dec_vec_s;
  logic [NREG-1:0] busy_s;
  logic [NREG-1:0] err_vec_s;
  sb_cnt_t         cnt_s [NREG];
  logic            src1_hit_s;
  logic            src2_hit_s;
  logic            dst_full_s;
  logic            ds_stall_s;
  logic            illegal_issue_s;
  logic            err_sticky_r;

  assign inc_s = issue & dst_we & (dst_addr != ADDR_R0);
  assign dec_s = rt_we & (rt_addr != ADDR_R0);

  // r0 slot: never busy, never counts, never errors
  assign inc_vec_s[0] = 1'b0;
  assign dec_vec_s[0] = 1'b0;
  assign busy_s[0]    = 1'b0;
  assign err_vec_s[0] = 1'b0;
  assign cnt_s[0]     = SB_CNT_ZERO;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
      assign inc_vec_s[gi] = inc_s & (dst_addr == AW'(gi));
      assign dec_vec_s[gi] = dec_s & (rt_addr == AW'(gi));

      ds_scoreboard_sb_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_vec_s[gi]),
        .dec   (dec_vec_s[gi]),
        .clr   (flush),
        .cnt   (cnt_s[gi]),
        .busy  (busy_s[gi]),
        .err   (err_vec_s[gi])
      );
    end
  endgenerate

  // Hazard detection. There is deliberately no retire bypass: a source that
  // retires this cycle still stalls, because the regfile only updates at the edge.
  always_comb begin
    src1_hit_s = src1_used & busy_s[src1_addr];
    src2_hit_s = src2_used & busy_s[src2_addr];
    dst_full_s = dst_we & (cnt_s[dst_addr] == SB_CNT_MAX);
    ds_stall_s = ds_valid & (src1_hit_s | src2_hit_s | dst_full_s);
  end

  assign illegal_issue_s = issue & ds_stall_s;

  // sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky_r <= 1'b0;
    end else begin
      err_sticky_r <= err_sticky_r | (|err_vec_s) | illegal_issue_s;
    end
  end

  assign ds_stall   = ds_stall_s;
  assign busy_vec   = busy_s;
  assign err_sticky = err_sticky_r;

endmodule
